// File: rtl/input_conditioner.sv
// Multi-channel synchronizer and debouncer with registered edge pulses.
// Pulses stay suppressed until the flush counter reports the pipeline as settled.
module input_conditioner #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 3,
    parameter int DB_CYCLES = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] InSignal,
    output logic [WIDTH-1:0] OutSignal,
    output logic [WIDTH-1:0] RisePulse,
    output logic [WIDTH-1:0] FallPulse,
    output logic             Ready
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam int FLUSH = STAGES + DB_CYCLES;
    localparam int RDY_W = $clog2(FLUSH);
    localparam logic [RDY_W-1:0] RDY_MAX = RDY_W'(FLUSH - 1);
    localparam logic [RDY_W-1:0] RDY_ONE = RDY_W'(1);

    logic [STAGES-1:0] sync_q [WIDTH];
    logic [CNT_W-1:0]  cnt_q  [WIDTH];
    logic [RDY_W-1:0]  rdy_cnt_q;
    logic [WIDTH-1:0]  sync_out;
    logic [WIDTH-1:0]  differ;
    logic [WIDTH-1:0]  accept;

    always_comb begin
        sync_out = '0;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sync_out[i] = sync_q[i][STAGES-1];
        end
        differ = sync_out ^ OutSignal;
        for (int i = 0; i < WIDTH; i++) begin
            accept[i] = differ[i] && (cnt_q[i] == CNT_MAX);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            OutSignal <= '0;
            RisePulse <= '0;
            FallPulse <= '0;
            rdy_cnt_q <= '0;
            Ready     <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                sync_q[i] <= {sync_q[i][STAGES-2:0], InSignal[i]};
                // A run of disagreement restarts from zero whenever it is broken or accepted.
                if (!differ[i] || accept[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
                end
            end
            OutSignal <= OutSignal ^ accept;
            RisePulse <= Ready ? (accept & sync_out)  : '0;
            FallPulse <= Ready ? (accept & ~sync_out) : '0;
            if (!Ready) begin
                if (rdy_cnt_q == RDY_MAX) begin
                    Ready <= 1'b1;
                end else begin
                    rdy_cnt_q <= rdy_cnt_q + RDY_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: two configurations side by side, compared every cycle
// against a sample-history window model of the debounce rules.
module tb_input_conditioner;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] in_a, in_b;
    logic [3:0] out_a, rise_a, fall_a;
    logic [3:0] out_b, rise_b, fall_b;
    logic       rdy_a, rdy_b;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    input_conditioner #(.WIDTH(4), .STAGES(3), .DB_CYCLES(4)) dut_a (
        .Clk(Clk), .Rst(Rst), .InSignal(in_a),
        .OutSignal(out_a), .RisePulse(rise_a), .FallPulse(fall_a), .Ready(rdy_a)
    );

    input_conditioner #(.WIDTH(4), .STAGES(2), .DB_CYCLES(1)) dut_b (
        .Clk(Clk), .Rst(Rst), .InSignal(in_b),
        .OutSignal(out_b), .RisePulse(rise_b), .FallPulse(fall_b), .Ready(rdy_b)
    );

    // Model: hist holds the raw input sampled at each edge since reset (edge 1 = first
    // edge after release). The synchronized value seen at edge m is raw(m - STAGES).
    int         stg [2] = '{3, 2};
    int         db  [2] = '{4, 1};
    logic [3:0] hist [2][16];
    int         m_edge [2];
    logic [3:0] m_out  [2];
    logic [3:0] m_rise [2];
    logic [3:0] m_fall [2];
    logic       m_rdy  [2];

    function automatic logic [3:0] raw_at(int c, int k);
        if (k < 1) return 4'b0000;
        return hist[c][k % 16];
    endfunction

    task automatic model_edge(input int c, input logic rst_v, input logic [3:0] in_v);
        logic [3:0] nxt;
        logic [3:0] sv;
        logic       acc;
        if (rst_v) begin
            m_edge[c] = 0;
            m_out[c]  = 4'b0000;
            m_rise[c] = 4'b0000;
            m_fall[c] = 4'b0000;
            m_rdy[c]  = 1'b0;
            return;
        end
        m_edge[c] = m_edge[c] + 1;
        hist[c][m_edge[c] % 16] = in_v;
        nxt = m_out[c];
        m_rise[c] = 4'b0000;
        m_fall[c] = 4'b0000;
        for (int ch = 0; ch < 4; ch++) begin
            // Accept when the last DB synchronized samples all oppose the current level.
            acc = (m_edge[c] >= db[c]);
            for (int j = 0; j < db[c]; j++) begin
                sv = raw_at(c, m_edge[c] - j - stg[c]);
                if (sv[ch] == m_out[c][ch]) acc = 1'b0;
            end
            if (acc) begin
                nxt[ch] = ~m_out[c][ch];
                if (m_rdy[c]) begin
                    if (nxt[ch]) m_rise[c][ch] = 1'b1;
                    else         m_fall[c][ch] = 1'b1;
                end
            end
        end
        m_out[c] = nxt;
        m_rdy[c] = (m_edge[c] >= stg[c] + db[c]);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_a",  out_a,  m_out[0]);
        chk("rise_a", rise_a, m_rise[0]);
        chk("fall_a", fall_a, m_fall[0]);
        chk("rdy_a",  {3'b000, rdy_a}, {3'b000, m_rdy[0]});
        chk("excl_a", rise_a & fall_a, 4'b0000);
        chk("out_b",  out_b,  m_out[1]);
        chk("rise_b", rise_b, m_rise[1]);
        chk("fall_b", fall_b, m_fall[1]);
        chk("rdy_b",  {3'b000, rdy_b}, {3'b000, m_rdy[1]});
        chk("excl_b", rise_b & fall_b, 4'b0000);
    endtask

    task automatic step(input logic rst_v);
        Rst = rst_v;
        @(posedge Clk);
        model_edge(0, rst_v, in_a);
        model_edge(1, rst_v, in_b);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b0);
    endtask

    initial begin
        in_a = 4'b0000;
        in_b = 4'b0000;
        // Idle reset and flush; Ready for config A rises after edge 7.
        step(1'b1);
        chk("reset_out_a", out_a, 4'b0000);
        run(6);
        chk("rdy_a_edge6", {3'b000, rdy_a}, 4'b0000);
        run(1);
        chk("rdy_a_edge7", {3'b000, rdy_a}, 4'b0001);
        run(3);

        // Single channel rising edge.
        in_a[0] = 1'b1;
        in_b[0] = 1'b1;
        run(10);
        chk("ch0_settled", out_a, 4'b0001);

        // Short pulse rejected, pulse of DB_CYCLES accepted.
        in_a[1] = 1'b1;
        run(3);
        in_a[1] = 1'b0;
        run(10);
        chk("glitch_rejected", out_a, 4'b0001);
        in_a[1] = 1'b1;
        run(4);
        in_a[1] = 1'b0;
        run(12);

        // Inputs held high through reset settle without rise pulses.
        in_a = 4'b1111;
        in_b = 4'b1111;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        run(12);
        chk("held_high_a", out_a, 4'b1111);

        // Reset in the middle of a debounce run, then requalify with full latency.
        in_a = 4'b0000;
        in_b = 4'b0000;
        step(1'b1);
        run(10);
        in_a[2] = 1'b1;
        run(5);
        step(1'b1);
        run(15);

        // All channels rise together on both configurations.
        in_a = 4'b0000;
        in_b = 4'b0000;
        run(10);
        in_a = 4'b1111;
        in_b = 4'b1111;
        run(10);

        // Random toggling with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 5) == 0) in_a[ch] = ~in_a[ch];
                if ($urandom_range(0, 2) == 0) in_b[ch] = ~in_b[ch];
            end
            step($urandom_range(0, 299) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter WIDTH, default 4: number of independent asynchronous input channels, legal range 1..32.
REQ-002 Parameter STAGES, default 3: synchronizer flop depth per channel, legal range 2..8.
REQ-003 Parameter DB_CYCLES, default 16: consecutive agreeing synchronized samples required to accept a new level, legal range 1..65535.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 InSignal  input  WIDTH  asynchronous raw inputs (switches/buttons), no timing relation to Clk.
REQ-007 OutSignal  output  WIDTH  synchronized, debounced level per channel, registered.
REQ-008 RisePulse  output  WIDTH  one-cycle pulse per channel on accepted 0->1 transition, registered.
REQ-009 FallPulse  output  WIDTH  one-cycle pulse per channel on accepted 1->0 transition, registered.
REQ-010 Ready  output  1  high once synchronizer and debounce pipeline have flushed after reset, registered.

Function
REQ-011 Each channel SHALL pass InSignal[i] through a chain of STAGES flops; synchronized value s[i] = last flop; no logic between chain flops.
REQ-012 Each channel SHALL hold a debounce counter cnt[i] of width ceil(log2(DB_CYCLES+1)); cnt[i] never exceeds DB_CYCLES-1, never wraps.
REQ-013 On each edge where s[i] == OutSignal[i]: cnt[i] <= 0, OutSignal[i] unchanged.
REQ-014 On each edge where s[i] != OutSignal[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1, OutSignal[i] unchanged.
REQ-015 On each edge where s[i] != OutSignal[i] and cnt[i] == DB_CYCLES-1: OutSignal[i] <= s[i], cnt[i] <= 0.
REQ-016 Latency: InSignal[i] changed and stable before edge E -> OutSignal[i] shows new value after edge E+STAGES+DB_CYCLES-1; DB_CYCLES=1 gives pure STAGES+0 debounce delay plus one register.
REQ-017 Glitch rejection: s[i] disagreeing with OutSignal[i] for fewer than DB_CYCLES consecutive edges SHALL leave OutSignal[i] unchanged and produce no pulse.
REQ-018 RisePulse[i] SHALL be high exactly in the cycle OutSignal[i] first shows 1 after showing 0, and low otherwise; FallPulse[i] symmetric for 1->0.
REQ-019 RisePulse[i] and FallPulse[i] SHALL never be high in the same cycle; consecutive pulses on one channel SHALL be separated by at least DB_CYCLES cycles.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on multiple channels produce pulses in the same cycle on each.
REQ-021 Ready SHALL be driven by a saturating counter: low for the first STAGES+DB_CYCLES edges after Rst deasserts, then high until next reset.
REQ-022 While Ready is low, RisePulse and FallPulse SHALL be forced 0; OutSignal still updates (an input held high through reset settles to OutSignal=1 with no RisePulse).

Reset
REQ-023 Rst high at an edge SHALL clear all synchronizer flops, all cnt[i], OutSignal, RisePulse, FallPulse, Ready and the Ready counter to 0.
REQ-024 Rst SHALL override all other activity; reset mid-debounce discards partial counts and the pending transition, restarting the flush per REQ-021.
REQ-025 Rst is sampled only on Clk rising edges; it has no asynchronous effect.

Verification
REQ-026 WIDTH=4, STAGES=3, DB_CYCLES=4; Rst 1 cycle, InSignal=0 -> all outputs 0; Ready rises after edge 7 post-reset.
REQ-027 Same config, Ready=1, InSignal[0] 0->1 held before edge E -> OutSignal[0]=1 and RisePulse[0]=1 for one cycle after edge E+6; other channels quiet.
REQ-028 InSignal[1] high pulse of 3 Clk cycles (< DB_CYCLES) -> OutSignal[1] stays 0, no pulses; a 4-cycle pulse -> accepted, RisePulse then FallPulse each one cycle.
REQ-029 InSignal=4'b1111 held through reset -> OutSignal=4'b1111 after flush, RisePulse never asserted, Ready=1 after edge 7.
REQ-030 InSignal[2] toggled mid-count, then Rst asserted at count 2 -> cnt cleared, OutSignal[2]=0, Ready=0; after release, transition re-qualifies with full latency.
REQ-031 InSignal[3:0] 0->1 on all channels same cycle, then DB_CYCLES=1, STAGES=2 rerun -> all RisePulse bits high same cycle; latency E+2 for second config.
